// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment driver: hex/decimal display, leading-zero blanking,
// per-digit decimal points, 16-level PWM. Optional per-digit blink under SEG7_BLINK_EN.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_CYCLES = 100000,
    parameter int BLINK_CYCLES   = 50000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    mode,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [3:0]              brightness,
`ifdef SEG7_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink,
`endif
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    busy
);
    // state    | meaning
    // ST_IDLE  | waiting for a load (live or pending)
    // ST_SHIFT | double-dabble add-3-then-shift iterations
    // ST_DONE  | write BCD result, chain a pending decimal request
    localparam int W      = 4 * NUM_DIGITS;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TMR_W  = $clog2(REFRESH_CYCLES);
    localparam int ITER_W = $clog2(W);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(REFRESH_CYCLES - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(W - 1);
    localparam logic [W-1:0]      MAX_DEC   = W'(10**NUM_DIGITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || REFRESH_CYCLES < 16 || BLINK_CYCLES < 1) begin : g_bad_params
        $error("seg7_scan_ctrl: parameter out of range");
    end

    logic [1:0]        state;
    logic [W-1:0]      disp_reg;
    logic              ovf;
    logic              blank_q;
    logic [W-1:0]      bin_sr;
    logic [W-1:0]      bcd_sr;
    logic [W-1:0]      bcd_adj;
    logic [ITER_W-1:0] iter_cnt;
    logic              conv_blank;
    logic              pend_valid;
    logic [W-1:0]      pend_value;
    logic              pend_mode;
    logic              pend_blank;

    logic              req_valid;
    logic              req_conv;
    logic [W-1:0]      req_value;
    logic              req_mode;
    logic              req_blank;

    // A live load always supersedes an older pending request.
    always_comb begin
        req_value = pend_value;
        req_mode  = pend_mode;
        req_blank = pend_blank;
        if (load) begin
            req_value = value;
            req_mode  = mode;
            req_blank = blank_lz;
        end
    end

    assign req_valid = load | pend_valid;
    assign req_conv  = req_valid & req_mode & (req_value <= MAX_DEC);

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            disp_reg   <= '0;
            ovf        <= 1'b0;
            blank_q    <= 1'b0;
            bin_sr     <= '0;
            bcd_sr     <= '0;
            iter_cnt   <= '0;
            conv_blank <= 1'b0;
            pend_valid <= 1'b0;
            pend_value <= '0;
            pend_mode  <= 1'b0;
            pend_blank <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        pend_valid <= 1'b0;
                        if (req_conv) begin
                            state      <= ST_SHIFT;
                            busy       <= 1'b1;
                            bin_sr     <= req_value;
                            bcd_sr     <= '0;
                            iter_cnt   <= ITER_LAST;
                            conv_blank <= req_blank;
                        end else if (req_mode) begin
                            ovf <= 1'b1;
                        end else begin
                            disp_reg <= req_value;
                            ovf      <= 1'b0;
                            blank_q  <= req_blank;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (load) begin
                        pend_valid <= 1'b1;
                        pend_value <= value;
                        pend_mode  <= mode;
                        pend_blank <= blank_lz;
                    end
                    bcd_sr <= {bcd_adj[W-2:0], bin_sr[W-1]};
                    bin_sr <= {bin_sr[W-2:0], 1'b0};
                    if (iter_cnt == '0) state <= ST_DONE;
                    else                iter_cnt <= iter_cnt - 1'b1;
                end
                ST_DONE: begin
                    disp_reg <= bcd_sr;
                    ovf      <= 1'b0;
                    blank_q  <= conv_blank;
                    if (req_conv) begin
                        state      <= ST_SHIFT;
                        pend_valid <= 1'b0;
                        bin_sr     <= req_value;
                        bcd_sr     <= '0;
                        iter_cnt   <= ITER_LAST;
                        conv_blank <= req_blank;
                    end else begin
                        // hex or overflowing requests are handled from IDLE next cycle
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (load) begin
                            pend_valid <= 1'b1;
                            pend_value <= value;
                            pend_mode  <= mode;
                            pend_blank <= blank_lz;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    logic [TMR_W-1:0] timer;
    logic [IDX_W-1:0] idx;
    logic [3:0]       pwm_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            idx     <= '0;
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            if (timer == TMR_LAST) begin
                timer <= '0;
                idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    logic blink_off;
`ifdef SEG7_BLINK_EN
    localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blink_off = blink_phase & blink[idx];
`else
    assign blink_off = 1'b0;
`endif

    function automatic logic [6:0] hex_glyph(input logic [3:0] d);
        case (d)
            4'h0: hex_glyph = 7'h40;  4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;  4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;  4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;  4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;  4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;  4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;  4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;  default: hex_glyph = 7'h0E;
        endcase
    endfunction

    logic [IDX_W-1:0]      msd;
    logic [3:0]            nibble;
    logic                  blanked;
    logic [NUM_DIGITS-1:0] an_next;

    always_comb begin
        msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++)
            if (disp_reg[4*i +: 4] != 4'd0) msd = IDX_W'(i);
    end

    assign nibble  = disp_reg[{idx, 2'b00} +: 4];
    assign blanked = blank_q & ~ovf & (idx > msd);

    always_comb begin
        an_next = '1;
        if (!blanked && !blink_off && pwm_cnt <= brightness) an_next[idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= 7'h7F;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            seg <= blanked ? 7'h7F : (ovf ? 7'h3F : hex_glyph(nibble));
            dp  <= blanked | ~dp_in[idx];
            an  <= an_next;
        end
    end
endmodule
